// File: rtl/md_seq.sv
// md_seq -- multi-cycle sequencer in front of the single-cycle HI/LO
// multiply/divide unit.
//
// It accepts one mult/multu/div/divu/mthi/mtlo request from decode and
// latches the operands. A countdown then models the real iterative latency,
// and afterwards exactly one write command (md_da, md_db, md_op) goes to the
// md unit. The block also produces the decode-stage stall for HI/LO readers
// and for back-to-back md requests.
//
// Parameters:
//   MUL_LAT  RUN cycles for mult/multu (1..63)
//   DIV_LAT  RUN cycles for div/divu   (1..63)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     decode presents an md request
//   op        000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//             (110/111 are ignored)
//   a, b      rs / rt operands, captured when the request is accepted
//   use_hilo  decode holds mfhi/mflo
//   abort     exception flush; cancels an op that is still in RUN
//   busy      sequencer not idle
//   stall     freeze decode stage
//   md_da     operand A to the md unit
//   md_db     operand B to the md unit
//   md_op     write command to the md unit (3'b111 = no write)
//   done      one-cycle pulse in the commit cycle
//   div0      (MD_DIV0_TRAP_EN only) pulses with done for a trapped
//             divide by zero
//
// Optional feature, macro MD_DIV0_TRAP_EN:
//   When it is defined, a div/divu accepted with b == 0 skips RUN and commits
//   a no-write (md_op 3'b111) together with div0. When it is undefined, a
//   divide by zero runs the full latency and commits normally.

module md_seq #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        use_hilo,
  input  logic        abort,
  output logic        busy,
  output logic        stall,
  output logic [31:0] md_da,
  output logic [31:0] md_db,
  output logic [2:0]  md_op,
  output logic        done
`ifdef MD_DIV0_TRAP_EN
  ,
  output logic        div0
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [2:0] OP_NONE = 3'b111;

  // The countdown is loaded with LAT-1 so that the counter reaches zero in
  // the last RUN cycle, which gives exactly LAT cycles in RUN.
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
`ifdef MD_DIV0_TRAP_EN
  logic        div0_q, div0_d;
`endif

  // Next-state logic. A new request is only considered in IDLE, so a request
  // that arrives while busy stays held by the stalled decode stage until the
  // first IDLE cycle. abort takes priority over the end-of-count transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef MD_DIV0_TRAP_EN
    div0_d  = div0_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !op[2]) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = op[1] ? DIV_CNT : MUL_CNT;
          state_d = RUN;
`ifdef MD_DIV0_TRAP_EN
          div0_d  = 1'b0;
          // A trapped divide by zero commits a no-write straight away.
          if (op[1] && (b == 32'd0)) begin
            op_d    = OP_NONE;
            cnt_d   = 6'd0;
            div0_d  = 1'b1;
            state_d = COMMIT;
          end
`endif
        end else if (start && !op[1]) begin
          // mthi/mtlo have no iterative latency.
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = COMMIT;
`ifdef MD_DIV0_TRAP_EN
          div0_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd0) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= OP_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
`ifdef MD_DIV0_TRAP_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef MD_DIV0_TRAP_EN
      div0_q  <= div0_d;
`endif
    end
  end

  // The md command is decoded only from registered state, so no input ever
  // reaches md_op/md_da/md_db/done combinationally. stall is the exception:
  // it has to react to the request that is on decode's inputs in this cycle.
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == COMMIT);
  assign md_op = done ? op_q : OP_NONE;
  assign md_da = a_q;
  assign md_db = b_q;
  assign stall = busy & (start | use_hilo);
`ifdef MD_DIV0_TRAP_EN
  assign div0  = done & div0_q;
`endif

endmodule
